wb_cmd_master: RTL and testbench

Single-beat Wishbone classic initiator that converts a valid/ready command stream into Wishbone read/write cycles and returns one response per command. It drives the upstream end of the same Wishbone slave bus the user project exposes to the management SoC. On-chip sources (LA-driven test sequencer, DMA descriptor fetch) use it to exercise or bridge into any Wishbone responder. It includes a bus timeout, so a dead responder never hangs the requester.

---
 rtl/wb_master_pkg.sv | 23 ++
 rtl/wb_cmd_master.sv | 177 +++++++++++++++++
 tb/tb_wb_cmd_master.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// Shared types and constants for the single-beat Wishbone command master
// and the blocks that consume its responses (e.g. the DMA descriptor fetcher).
package wb_master_pkg;

    // Default bus widths
    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;

    // Master sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    // How a bus cycle terminated
    typedef enum logic [1:0] {
        RSP_OK  = 2'd0,
        RSP_ERR = 2'd1,
        RSP_TMO = 2'd2
    } rsp_kind_e;

endpackage

// File: rtl/wb_cmd_master.sv
// Single-beat Wishbone classic initiator: one command in, one bus cycle,
// one response out. A watchdog aborts cycles to responders that never answer.
// Every output comes straight from a flop.
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int ADR_W   = WB_ADR_W,
    parameter int DAT_W   = WB_DAT_W,
    parameter int TIMEOUT = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_we,
    input  logic [ADR_W-1:0]   cmd_adr,
    input  logic [DAT_W-1:0]   cmd_dat,
    input  logic [DAT_W/8-1:0] cmd_sel,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DAT_W-1:0]   rsp_dat,
    output logic               rsp_err,
    output logic               rsp_tmo,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [DAT_W/8-1:0] wbm_sel_o,
    output logic [ADR_W-1:0]   wbm_adr_o,
    output logic [DAT_W-1:0]   wbm_dat_o,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    input  logic [DAT_W-1:0]   wbm_dat_i
);

    // Counter value on the last allowed strobe cycle
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e               state_q,     state_d;
    logic [15:0]          cnt_q,       cnt_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 cyc_q,       cyc_d;
    logic                 we_q,        we_d;
    logic [DAT_W/8-1:0]   sel_q,       sel_d;
    logic [ADR_W-1:0]     adr_q,       adr_d;
    logic [DAT_W-1:0]     dat_q,       dat_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0]     rsp_dat_q,   rsp_dat_d;
    logic                 rsp_err_q,   rsp_err_d;
    logic                 rsp_tmo_q,   rsp_tmo_d;

    rsp_kind_e            kind_s;
    logic                 done_s;
    logic [DAT_W-1:0]     rdat_s;

    // Next-state and next-output logic; outputs are computed one cycle ahead
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        rsp_tmo_d   = rsp_tmo_q;
        kind_s      = RSP_OK;
        done_s      = 1'b0;
        rdat_s      = {DAT_W{1'b0}};

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d     = BUS;
                    cnt_d       = 16'd0;
                    cmd_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    we_d        = cmd_we;
                    sel_d       = cmd_sel;
                    adr_d       = cmd_adr;
                    dat_d       = cmd_dat;
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                // err beats ack, and any termination beats the watchdog
                if (wbm_err_i) begin
                    kind_s = RSP_ERR;
                    done_s = 1'b1;
                end else if (wbm_ack_i) begin
                    kind_s = RSP_OK;
                    done_s = 1'b1;
                    rdat_s = we_q ? {DAT_W{1'b0}} : wbm_dat_i;
                end else if (cnt_q == TMO_LAST) begin
                    kind_s = RSP_TMO;
                    done_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end

                if (done_s) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = rdat_s;
                    rsp_err_d   = (kind_s == RSP_ERR);
                    rsp_tmo_d   = (kind_s == RSP_TMO);
                end else begin
                    state_d = BUS;
                end
            end
            RESP: begin
                // No command is taken in the cycle the response retires
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State, watchdog and output registers with synchronous reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            cmd_ready_q <= 1'b1;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= {(DAT_W/8){1'b0}};
            adr_q       <= {ADR_W{1'b0}};
            dat_q       <= {DAT_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= {DAT_W{1'b0}};
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_tmo   = rsp_tmo_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with an 8-cycle watchdog. Inputs change
// and outputs are sampled 1 ns after each rising edge.
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i, wbm_err_i;
    logic [31:0] wbm_dat_i;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(.ADR_W(32), .DAT_W(32), .TIMEOUT(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_dat_i(wbm_dat_i)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one command and let it be accepted (bounded wait for cmd_ready)
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int k;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 10) begin step(); k++; end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL issue_ready: got %b need 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = a; cmd_dat = d; cmd_sel = s;
        step();
        cmd_valid = 1'b0;
    endtask

    // Retire the pending response
    task automatic drain();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_cmp++; if (cmd_ready !== 1'b1)     begin n_err++; $display("FAIL rst_cmd_ready: got %b need 1", cmd_ready); end
        n_cmp++; if (wbm_cyc_o !== 1'b0)     begin n_err++; $display("FAIL rst_cyc: got %b need 0", wbm_cyc_o); end
        n_cmp++; if (wbm_stb_o !== 1'b0)     begin n_err++; $display("FAIL rst_stb: got %b need 0", wbm_stb_o); end
        n_cmp++; if (wbm_we_o !== 1'b0)      begin n_err++; $display("FAIL rst_we: got %b need 0", wbm_we_o); end
        n_cmp++; if (rsp_valid !== 1'b0)     begin n_err++; $display("FAIL rst_rsp_valid: got %b need 0", rsp_valid); end
        n_cmp++; if (wbm_adr_o !== 32'h0)    begin n_err++; $display("FAIL rst_adr: got %h need 0", wbm_adr_o); end
        n_cmp++; if (wbm_dat_o !== 32'h0)    begin n_err++; $display("FAIL rst_dat: got %h need 0", wbm_dat_o); end
        n_cmp++; if (wbm_sel_o !== 4'h0)     begin n_err++; $display("FAIL rst_sel: got %h need 0", wbm_sel_o); end
        n_cmp++; if ({rsp_err, rsp_tmo} !== 2'b00 || rsp_dat !== 32'h0) begin n_err++; $display("FAIL rst_rsp_fields: got err=%b tmo=%b dat=%h need 0", rsp_err, rsp_tmo, rsp_dat); end
        rst = 1'b0;
        step();
        n_cmp++; if (cmd_ready !== 1'b1)     begin n_err++; $display("FAIL rst_release_ready: got %b need 1", cmd_ready); end
    endtask

    task automatic test_write_zero_wait();
        issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        n_cmp++; if ({wbm_cyc_o, wbm_stb_o} !== 2'b11) begin n_err++; $display("FAIL wr_cyc_stb: got %b%b need 11", wbm_cyc_o, wbm_stb_o); end
        n_cmp++; if (wbm_we_o !== 1'b1)            begin n_err++; $display("FAIL wr_we: got %b need 1", wbm_we_o); end
        n_cmp++; if (wbm_adr_o !== 32'h3000_0004)  begin n_err++; $display("FAIL wr_adr: got %h need 30000004", wbm_adr_o); end
        n_cmp++; if (wbm_dat_o !== 32'hDEAD_BEEF)  begin n_err++; $display("FAIL wr_dat: got %h need deadbeef", wbm_dat_o); end
        n_cmp++; if (wbm_sel_o !== 4'hF)           begin n_err++; $display("FAIL wr_sel: got %h need f", wbm_sel_o); end
        n_cmp++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_busy: got ready=%b valid=%b need 0 0", cmd_ready, rsp_valid); end
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h5555_AAAA;
        step();
        wbm_ack_i = 1'b0;
        n_cmp++; if (wbm_stb_o !== 1'b0)   begin n_err++; $display("FAIL wr_stb_len: stb still %b after 1 cycle, need 0", wbm_stb_o); end
        n_cmp++; if (rsp_valid !== 1'b1)   begin n_err++; $display("FAIL wr_latency: rsp_valid %b at 2 cycles, need 1", rsp_valid); end
        n_cmp++; if (rsp_dat !== 32'h0)    begin n_err++; $display("FAIL wr_rsp_dat: got %h need 0", rsp_dat); end
        n_cmp++; if ({rsp_err, rsp_tmo} !== 2'b00) begin n_err++; $display("FAIL wr_rsp_flags: got %b%b need 00", rsp_err, rsp_tmo); end
        drain();
        n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL wr_retire: got valid=%b ready=%b need 0 1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_read_wait();
        int n_stb;
        n_stb = 0;
        issue(1'b0, 32'h3000_0100, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            if (wbm_stb_o === 1'b1) n_stb++;
            n_cmp++; if (wbm_adr_o !== 32'h3000_0100 || wbm_we_o !== 1'b0) begin n_err++; $display("FAIL rd_hold: got adr=%h we=%b need 30000100 0", wbm_adr_o, wbm_we_o); end
            if (i == 3) begin wbm_ack_i = 1'b1; wbm_dat_i = 32'h1234_5678; end
            step();
        end
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        n_cmp++; if (n_stb !== 4 || wbm_stb_o !== 1'b0) begin n_err++; $display("FAIL rd_stb_len: got %0d then stb=%b need 4 then 0", n_stb, wbm_stb_o); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'h1234_5678 || rsp_err !== 1'b0 || rsp_tmo !== 1'b0) begin
                n_err++; $display("FAIL rd_rsp_hold%0d: got v=%b dat=%h e=%b t=%b need 1 12345678 0 0", i, rsp_valid, rsp_dat, rsp_err, rsp_tmo);
            end
            step();
        end
        drain();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_retire: got %b need 0", rsp_valid); end
    endtask

    task automatic test_error();
        issue(1'b0, 32'h3000_0200, 32'h0, 4'hF);
        wbm_err_i = 1'b1; wbm_dat_i = 32'hFFFF_FFFF;
        step();
        wbm_err_i = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_tmo !== 1'b0 || rsp_dat !== 32'h0) begin
            n_err++; $display("FAIL err_only: got v=%b e=%b t=%b dat=%h need 1 1 0 0", rsp_valid, rsp_err, rsp_tmo, rsp_dat);
        end
        drain();
        issue(1'b0, 32'h3000_0204, 32'h0, 4'h1);
        wbm_err_i = 1'b1; wbm_ack_i = 1'b1; wbm_dat_i = 32'hCAFE_F00D;
        step();
        wbm_err_i = 1'b0; wbm_ack_i = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_tmo !== 1'b0 || rsp_dat !== 32'h0) begin
            n_err++; $display("FAIL err_ack_collide: got v=%b e=%b t=%b dat=%h need 1 1 0 0", rsp_valid, rsp_err, rsp_tmo, rsp_dat);
        end
        drain();
    endtask

    task automatic test_timeout();
        int n_stb;
        int n_rsp;
        n_stb = 0; n_rsp = 0;
        wbm_dat_i = 32'h7777_7777;
        issue(1'b0, 32'h3000_0300, 32'h0, 4'hF);
        while (wbm_stb_o === 1'b1 && n_stb < 20) begin n_stb++; step(); end
        n_cmp++; if (n_stb !== 8) begin n_err++; $display("FAIL tmo_stb_len: got %0d need 8", n_stb); end
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_tmo !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h0) begin
            n_err++; $display("FAIL tmo_rsp: got v=%b t=%b e=%b dat=%h need 1 1 0 0", rsp_valid, rsp_tmo, rsp_err, rsp_dat);
        end
        drain();
        step();
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid === 1'b1 || wbm_cyc_o === 1'b1) n_rsp++;
            step();
        end
        n_cmp++; if (n_rsp !== 0) begin n_err++; $display("FAIL tmo_late_ack: %0d busy/valid cycles after late ack, need 0", n_rsp); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL tmo_idle: cmd_ready got %b need 1", cmd_ready); end
    endtask

    task automatic test_ack_at_expiry();
        int n_stb;
        n_stb = 0;
        issue(1'b0, 32'h3000_0010, 32'h0, 4'h3);
        for (int i = 0; i < 8; i++) begin
            if (wbm_stb_o === 1'b1) n_stb++;
            if (i == 7) begin wbm_ack_i = 1'b1; wbm_dat_i = 32'hA5A5_0F0F; end
            step();
        end
        wbm_ack_i = 1'b0;
        n_cmp++; if (n_stb !== 8) begin n_err++; $display("FAIL exp_stb_len: got %0d need 8", n_stb); end
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_tmo !== 1'b0 || rsp_err !== 1'b0 || rsp_dat !== 32'hA5A5_0F0F) begin
            n_err++; $display("FAIL exp_ack_wins: got v=%b t=%b e=%b dat=%h need 1 0 0 a5a50f0f", rsp_valid, rsp_tmo, rsp_err, rsp_dat);
        end
        drain();
    endtask

    task automatic test_reset_mid_bus();
        int n_v;
        n_v = 0;
        issue(1'b0, 32'h3000_0400, 32'h0, 4'hF);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if ({wbm_cyc_o, wbm_stb_o} !== 2'b00 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL rstbus_state: got cyc=%b stb=%b v=%b rdy=%b need 0 0 0 1", wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready);
        end
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid === 1'b1) n_v++;
            step();
        end
        n_cmp++; if (n_v !== 0) begin n_err++; $display("FAIL rstbus_no_rsp: got %0d valid cycles need 0", n_v); end
        issue(1'b1, 32'h3000_0008, 32'h0BAD_F00D, 4'h5);
        n_cmp++; if (wbm_adr_o !== 32'h3000_0008 || wbm_dat_o !== 32'h0BAD_F00D || wbm_sel_o !== 4'h5 || wbm_stb_o !== 1'b1) begin
            n_err++; $display("FAIL rstbus_next_bus: got adr=%h dat=%h sel=%h stb=%b need 30000008 0badf00d 5 1", wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_stb_o);
        end
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_tmo !== 1'b0 || rsp_dat !== 32'h0) begin
            n_err++; $display("FAIL rstbus_next_rsp: got v=%b e=%b t=%b dat=%h need 1 0 0 0", rsp_valid, rsp_err, rsp_tmo, rsp_dat);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int t0, t1, nh;
        t0 = 0; t1 = 0; nh = 0;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0020; cmd_dat = 32'h0000_0001; cmd_sel = 4'hF;
        for (int c = 0; c < 20 && nh < 2; c++) begin
            wbm_ack_i = wbm_stb_o;
            if (cmd_ready === 1'b1) begin
                if (nh == 0) t0 = c; else t1 = c;
                nh++;
            end
            step();
        end
        cmd_valid = 1'b0;
        wbm_ack_i = wbm_stb_o;
        step();
        wbm_ack_i = 1'b0;
        step();
        rsp_ready = 1'b0;
        n_cmp++; if (nh !== 2 || (t1 - t0) !== 3) begin n_err++; $display("FAIL b2b_period: got %0d accepts %0d cycles apart need 2 and 3", nh, t1 - t0); end
        n_cmp++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got rdy=%b v=%b need 1 0", cmd_ready, rsp_valid); end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0; cmd_sel = 4'h0;
        rsp_ready = 1'b0;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = 32'h0;
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_error();
        test_timeout();
        test_ack_at_expiry();
        test_reset_mid_bus();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
